// File: rtl/riscv_pkg.sv
// Shared types for the execute stage: ALU op codes, forward selects and
// the ID/EX and EX/MEM pipeline register layouts.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_SLL  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_e     alucontrol;
    logic        alusrc;
    logic        regwrite;
    logic        memwrite;
    logic [1:0]  resultsrc;
  } idex_t;

  typedef struct packed {
    logic [31:0] aluresult;
    logic [31:0] writedata;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memwrite;
    logic [1:0]  resultsrc;
  } exmem_t;

  // MEM beats WB because it holds the younger write; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       regwrite_m,
    input logic [4:0] rd_w,
    input logic       regwrite_w
  );
    if (rs != 5'd0 && regwrite_m && rd_m == rs)      return FWD_MEM;
    else if (rs != 5'd0 && regwrite_w && rd_w == rs) return FWD_WB;
    else                                             return FWD_REG;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; unused op codes give 0, shifts use b[4:0].
module alu
  import riscv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alucontrol,
  output logic [31:0] result,
  output logic        zero
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    result = 32'd0;
    case (alucontrol)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_SLTU: result = {31'd0, a < b};
      default:  result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX and EX/MEM registers, operand forwarding and ALU.
// A stall holds ID/EX and sends a bubble downstream; flush bubbles ID/EX.
module ex_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rd1_d,
  input  logic [31:0] rd2_d,
  input  logic [31:0] imm_ext_d,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  input  logic [3:0]  alucontrol_d,
  input  logic        alusrc_d,
  input  logic        regwrite_d,
  input  logic        memwrite_d,
  input  logic [1:0]  resultsrc_d,
  input  logic        stall_e,
  input  logic        flush_e,
  input  logic [4:0]  rd_w,
  input  logic        regwrite_w,
  input  logic [31:0] result_w,
  output logic [31:0] aluresult_m,
  output logic [31:0] writedata_m,
  output logic [4:0]  rd_m,
  output logic        regwrite_m,
  output logic        memwrite_m,
  output logic [1:0]  resultsrc_m,
  output logic        zero_e
);

  idex_t       idex, idex_next;
  exmem_t      exmem, exmem_next;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] srca, fwd_b_val, srcb, aluresult_e;

  always_comb begin
    idex_next            = '0;
    idex_next.rd1        = rd1_d;
    idex_next.rd2        = rd2_d;
    idex_next.imm_ext    = imm_ext_d;
    idex_next.rs1        = rs1_d;
    idex_next.rs2        = rs2_d;
    idex_next.rd         = rd_d;
    idex_next.alucontrol = alu_op_e'(alucontrol_d);
    idex_next.alusrc     = alusrc_d;
    idex_next.regwrite   = regwrite_d;
    idex_next.memwrite   = memwrite_d;
    idex_next.resultsrc  = resultsrc_d;
  end

  assign fwd_a = fwd_sel(idex.rs1, exmem.rd, exmem.regwrite, rd_w, regwrite_w);
  assign fwd_b = fwd_sel(idex.rs2, exmem.rd, exmem.regwrite, rd_w, regwrite_w);

  always_comb begin
    case (fwd_a)
      FWD_MEM: srca = exmem.aluresult;
      FWD_WB:  srca = result_w;
      default: srca = idex.rd1;
    endcase
    case (fwd_b)
      FWD_MEM: fwd_b_val = exmem.aluresult;
      FWD_WB:  fwd_b_val = result_w;
      default: fwd_b_val = idex.rd2;
    endcase
  end

  assign srcb = idex.alusrc ? idex.imm_ext : fwd_b_val;

  alu u_alu (
    .a          (srca),
    .b          (srcb),
    .alucontrol (idex.alucontrol),
    .result     (aluresult_e),
    .zero       (zero_e)
  );

  // Store data is always the forwarded register value, never the immediate.
  always_comb begin
    exmem_next           = '0;
    exmem_next.aluresult = aluresult_e;
    exmem_next.writedata = fwd_b_val;
    exmem_next.rd        = idex.rd;
    exmem_next.regwrite  = idex.regwrite;
    exmem_next.memwrite  = idex.memwrite;
    exmem_next.resultsrc = idex.resultsrc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex  <= '0;
      exmem <= '0;
    end else begin
      if (flush_e)       idex <= '0;
      else if (!stall_e) idex <= idex_next;

      if (stall_e) exmem <= '0;
      else         exmem <= exmem_next;
    end
  end

  assign aluresult_m = exmem.aluresult;
  assign writedata_m = exmem.writedata;
  assign rd_m        = exmem.rd;
  assign regwrite_m  = exmem.regwrite;
  assign memwrite_m  = exmem.memwrite;
  assign resultsrc_m = exmem.resultsrc;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: ALU vector table, hand-written hazard/stall/reset
// sequences and a randomized run against a cycle-level reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rd1_d, rd2_d, imm_ext_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [3:0]  alucontrol_d;
  logic        alusrc_d, regwrite_d, memwrite_d;
  logic [1:0]  resultsrc_d;
  logic        stall_e, flush_e;
  logic [4:0]  rd_w;
  logic        regwrite_w;
  logic [31:0] result_w;
  logic [31:0] aluresult_m, writedata_m;
  logic [4:0]  rd_m;
  logic        regwrite_m, memwrite_m;
  logic [1:0]  resultsrc_m;
  logic        zero_e;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .alucontrol_d(alucontrol_d), .alusrc_d(alusrc_d),
    .regwrite_d(regwrite_d), .memwrite_d(memwrite_d), .resultsrc_d(resultsrc_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .rd_w(rd_w), .regwrite_w(regwrite_w), .result_w(result_w),
    .aluresult_m(aluresult_m), .writedata_m(writedata_m), .rd_m(rd_m),
    .regwrite_m(regwrite_m), .memwrite_m(memwrite_m), .resultsrc_m(resultsrc_m),
    .zero_e(zero_e)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction sitting in execute and the one in memory.
  typedef struct {
    logic        v;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        alusrc, rw, mw;
    logic [1:0]  rsrc;
  } m_ex_t;

  typedef struct {
    logic        v;
    logic [31:0] res, wd;
    logic [4:0]  rd;
    logic        rw, mw;
    logic [1:0]  rsrc;
  } m_mem_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, exp;
  } vec_t;

  m_ex_t  mex;
  m_mem_t mmem;
  int     nvec = 0;
  int     nfail = 0;
  vec_t   vt[16];

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a ^ b;
      4'd4: return a << sh;
      4'd5: return a >> sh;
      4'd6: return a - b;
      4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: return $signed(a) >>> sh;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [4:0] rs, input logic [31:0] regval);
    if (rs != 5'd0 && mmem.rw && mmem.rd == rs) return mmem.res;
    if (rs != 5'd0 && regwrite_w && rd_w == rs) return result_w;
    return regval;
  endfunction

  function automatic logic [31:0] ex_result();
    logic [31:0] a, b;
    a = pick(mex.rs1, mex.rd1);
    b = mex.alusrc ? mex.imm : pick(mex.rs2, mex.rd2);
    return ref_alu(mex.op, a, b);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mex  = '{default: 0};
    mmem = '{default: 0};
  endtask

  task automatic tick();
    m_ex_t  nex;
    m_mem_t nmem;
    #1;
    if (mex.v) chk("zero_e", 32'(zero_e), (ex_result() == 32'd0) ? 32'd1 : 32'd0);
    if (stall_e) nmem = '{default: 0};
    else nmem = '{v: mex.v, res: ex_result(), wd: pick(mex.rs2, mex.rd2),
                  rd: mex.rd, rw: mex.rw, mw: mex.mw, rsrc: mex.rsrc};
    if (flush_e)      nex = '{default: 0};
    else if (stall_e) nex = mex;
    else nex = '{v: 1'b1, rd1: rd1_d, rd2: rd2_d, imm: imm_ext_d, rs1: rs1_d,
                 rs2: rs2_d, rd: rd_d, op: alucontrol_d, alusrc: alusrc_d,
                 rw: regwrite_d, mw: memwrite_d, rsrc: resultsrc_d};
    @(posedge clk);
    #1;
    mex  = nex;
    mmem = nmem;
    chk("rd_m", 32'(rd_m), 32'(mmem.rd));
    chk("regwrite_m", 32'(regwrite_m), 32'(mmem.rw));
    chk("memwrite_m", 32'(memwrite_m), 32'(mmem.mw));
    chk("resultsrc_m", 32'(resultsrc_m), 32'(mmem.rsrc));
    if (mmem.v) begin
      chk("aluresult_m", aluresult_m, mmem.res);
      chk("writedata_m", writedata_m, mmem.wd);
    end
  endtask

  task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic alusrc, input logic rw);
    alucontrol_d = op; rd1_d = a; rd2_d = b; imm_ext_d = imm;
    rs1_d = rs1; rs2_d = rs2; rd_d = rd; alusrc_d = alusrc;
    regwrite_d = rw; memwrite_d = 1'b0; resultsrc_d = 2'd0;
  endtask

  task automatic nop();
    set_in(4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_aluresult"}, aluresult_m, 32'd0);
    chk({nm, "_writedata"}, writedata_m, 32'd0);
    chk({nm, "_rd"}, 32'(rd_m), 32'd0);
    chk({nm, "_regwrite"}, 32'(regwrite_m), 32'd0);
    chk({nm, "_memwrite"}, 32'(memwrite_m), 32'd0);
    chk({nm, "_resultsrc"}, 32'(resultsrc_m), 32'd0);
  endtask

  initial begin
    vt[0]  = '{4'd6,  32'd7,        32'd5,        32'd2};
    vt[1]  = '{4'd7,  32'hFFFFFFFF, 32'd1,        32'd1};
    vt[2]  = '{4'd9,  32'hFFFFFFFF, 32'd1,        32'd0};
    vt[3]  = '{4'd8,  32'h80000000, 32'd4,        32'hF8000000};
    vt[4]  = '{4'd5,  32'h80000000, 32'd4,        32'h08000000};
    vt[5]  = '{4'd4,  32'h00000003, 32'd33,       32'h00000006};
    vt[6]  = '{4'd12, 32'h12345678, 32'h9ABCDEF0, 32'd0};
    vt[7]  = '{4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vt[8]  = '{4'd1,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0};
    vt[9]  = '{4'd2,  32'hFFFFFFFF, 32'd2,        32'd1};
    vt[10] = '{4'd3,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555};
    vt[11] = '{4'd6,  32'd0,        32'd1,        32'hFFFFFFFF};
    vt[12] = '{4'd7,  32'd1,        32'hFFFFFFFF, 32'd0};
    vt[13] = '{4'd9,  32'd1,        32'hFFFFFFFF, 32'd1};
    vt[14] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    vt[15] = '{4'd8,  32'h7FFFFFFF, 32'd31,       32'd0};

    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    rd_w = 5'd0; regwrite_w = 1'b0; result_w = 32'd0;
    nop();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("after_reset");

    // ALU op table, one instruction at a time.
    for (int i = 0; i < 16; i++) begin
      set_in(vt[i].op, vt[i].a, vt[i].b, 32'd0, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1);
      tick();
      if (vt[i].op == 4'd12) chk("zero_e_op12", 32'(zero_e), 32'd1);
      nop();
      tick();
      chk($sformatf("table%0d", i), aluresult_m, vt[i].exp);
    end

    // Immediate operand; store data is still the register value.
    set_in(4'd2, 32'd5, 32'd77, 32'd9, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1);
    tick(); nop(); tick();
    chk("imm_result", aluresult_m, 32'd14);
    chk("imm_writedata", writedata_m, 32'd77);

    // MEM forward, then same pair with rd=x0.
    set_in(4'd2, 32'd3, 32'd4, 32'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1);
    tick();
    set_in(4'd2, 32'd100, 32'd0, 32'd1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1);
    tick(); nop(); tick();
    chk("fwd_mem", aluresult_m, 32'd8);
    set_in(4'd2, 32'd3, 32'd4, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    tick();
    set_in(4'd2, 32'd0, 32'd0, 32'd1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
    tick(); nop(); tick();
    chk("fwd_x0", aluresult_m, 32'd1);

    // MEM and WB both match: MEM wins; then WB alone.
    rd_w = 5'd5; regwrite_w = 1'b1; result_w = 32'd20;
    set_in(4'd2, 32'd4, 32'd6, 32'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1);
    tick();
    set_in(4'd2, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0, 5'd7, 1'b0, 1'b1);
    tick(); nop(); tick();
    chk("fwd_prio", aluresult_m, 32'd10);
    set_in(4'd2, 32'd0, 32'd3, 32'd0, 5'd5, 5'd0, 5'd8, 1'b0, 1'b1);
    tick(); nop(); tick();
    chk("fwd_wb", aluresult_m, 32'd23);
    regwrite_w = 1'b0; rd_w = 5'd0;

    // Two-cycle stall on a sub, then stall+flush loses the held instruction.
    set_in(4'd6, 32'd9, 32'd4, 32'd0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1);
    tick();
    nop(); stall_e = 1'b1;
    tick(); chk("stall_bubble1", 32'(regwrite_m), 32'd0);
    tick(); chk("stall_bubble2", 32'(regwrite_m), 32'd0);
    stall_e = 1'b0;
    tick();
    chk("stall_release_res", aluresult_m, 32'd5);
    chk("stall_release_rw", 32'(regwrite_m), 32'd1);
    tick(); chk("stall_once", 32'(regwrite_m), 32'd0);
    set_in(4'd2, 32'd1, 32'd1, 32'd0, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1);
    tick();
    nop(); stall_e = 1'b1; flush_e = 1'b1;
    tick(); chk("stallflush_bubble", 32'(regwrite_m), 32'd0);
    stall_e = 1'b0; flush_e = 1'b0;
    tick(); chk("stallflush_lost", 32'(regwrite_m), 32'd0);

    // Reset pulse between edges clears an in-flight write.
    set_in(4'd2, 32'd1, 32'd2, 32'd0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1);
    tick(); nop(); tick();
    chk("pre_reset_rw", 32'(regwrite_m), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    #1 reset = 1'b0;
    model_clear();

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      set_in(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) rd1_d = {27'd0, rd1_d[4:0]};
      memwrite_d  = 1'($urandom_range(0, 1));
      resultsrc_d = 2'($urandom_range(0, 3));
      stall_e     = ($urandom_range(0, 7) == 0);
      flush_e     = ($urandom_range(0, 7) == 0);
      rd_w        = 5'($urandom_range(0, 3));
      regwrite_w  = 1'($urandom_range(0, 1));
      result_w    = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
